// File: rtl/dvp_frame_ctrl.sv
// Frame-level sequencer for the DVP capture path. Gates the capture block's
// pixel strobe per frame (single-shot, continuous, decimation, whole-frame
// drop on back-pressure) and checks per-frame line/pixel counts.
module dvp_frame_ctrl #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720,
  parameter int unsigned SKIP_W = 4,
  parameter int unsigned LAG    = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [SKIP_W-1:0] skip_n,
  input  logic              buf_ready,
  output logic              pix_valid_o,
  output logic              sof,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned PW = $clog2(WIDTH + 2);
  localparam int unsigned LW = $clog2(HEIGHT + 2);
  localparam logic [PW-1:0] PixExp  = PW'(WIDTH);
  localparam logic [PW-1:0] PixMax  = PW'(WIDTH + 1);
  localparam logic [LW-1:0] LineExp = LW'(HEIGHT);
  localparam logic [LW-1:0] LineMax = LW'(HEIGHT + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StSkip, StCapture} state_e;

  state_e            state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [LW-1:0]     line_cnt_q, line_cnt_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic              pix_err_q, pix_err_d;
  logic              sof_pend_q, sof_pend_d;
  logic              stop_req_q, stop_req_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              vs_q, hr_q;
  logic              vs_fall, vs_rise, hr_fall;
  logic [LAG-1:0]    le_sr_q, fe_sr_q;
  logic              line_end, frame_end;
  logic [LW-1:0]     line_cnt_n;
  logic              pix_err_n;

  // Edges are flagged in the cycle the new level first appears on the raw input.
  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = ~vs_q & vsync;
  assign hr_fall = hr_q & ~href;

  assign line_end  = le_sr_q[LAG-1];
  assign frame_end = fe_sr_q[LAG-1];

  // Raw sync registers and LAG-deep delay lines aligning edges with the pixel stream.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      le_sr_q <= '0;
      fe_sr_q <= '0;
    end else begin
      vs_q       <= vsync;
      hr_q       <= href;
      le_sr_q[0] <= hr_fall;
      fe_sr_q[0] <= vs_rise;
      for (int i = 1; i < LAG; i++) begin
        le_sr_q[i] <= le_sr_q[i-1];
        fe_sr_q[i] <= fe_sr_q[i-1];
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      skip_cnt_q   <= '0;
      line_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      pix_err_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      stop_req_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_code_q   <= 2'b00;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_err_q    <= pix_err_d;
      sof_pend_q   <= sof_pend_d;
      stop_req_q   <= stop_req_d;
      frame_done_q <= frame_done_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state logic: frame admission, counting and end-of-frame reporting.
  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    line_cnt_d   = line_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    pix_err_d    = pix_err_q;
    sof_pend_d   = sof_pend_q;
    stop_req_d   = stop_req_q | stop;
    frame_done_d = 1'b0;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    line_cnt_n   = line_cnt_q;
    pix_err_n    = pix_err_q;

    case (state_q)
      StIdle: begin
        // A stop seen while idle has nothing to stop; don't let it kill the next arm.
        stop_req_d = 1'b0;
        if (start && !stop) begin
          state_d    = StArmed;
          skip_cnt_d = skip_n;
        end
      end

      StArmed: begin
        if (stop || stop_req_q) begin
          state_d    = StIdle;
          stop_req_d = 1'b0;
        end else if (vs_fall) begin
          if (skip_cnt_q != '0) begin
            skip_cnt_d = skip_cnt_q - 1'b1;
            state_d    = StSkip;
          end else if (buf_ready) begin
            state_d    = StCapture;
            line_cnt_d = '0;
            pix_cnt_d  = '0;
            pix_err_d  = 1'b0;
            sof_pend_d = 1'b1;
          end else begin
            // skip_cnt stays 0 so the very next frame is tried again.
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d = StSkip;
          end
        end
      end

      StSkip: begin
        if (stop || stop_req_q) begin
          state_d    = StIdle;
          stop_req_d = 1'b0;
        end else if (frame_end) begin
          state_d = StArmed;
        end
      end

      StCapture: begin
        if (pix_valid) sof_pend_d = 1'b0;
        if (line_end) begin
          pix_err_n  = pix_err_q | (pix_cnt_q != PixExp);
          line_cnt_n = (line_cnt_q != LineMax) ? line_cnt_q + 1'b1 : line_cnt_q;
          // A pixel coincident with line_end belongs to the next line.
          pix_cnt_d  = {{(PW-1){1'b0}}, pix_valid};
        end else if (pix_valid && pix_cnt_q != PixMax) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
        line_cnt_d = line_cnt_n;
        pix_err_d  = pix_err_n;
        if (frame_end) begin
          frame_done_d = 1'b1;
          err_code_d   = {pix_err_n, line_cnt_n != LineExp};
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (continuous && !stop_req_d) begin
            state_d    = StArmed;
            skip_cnt_d = skip_n;
          end else begin
            state_d    = StIdle;
            stop_req_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pixel gating is purely combinational so it adds no latency to the data path.
  assign pix_valid_o = pix_valid & (state_q == StCapture);
  assign sof         = pix_valid_o & sof_pend_q;
  assign busy        = state_q != StIdle;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_done_q & (|err_code_q);
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/dvp_frame_ctrl.md
Name: dvp_frame_ctrl

Overview:
- Frame-level sequencer for the DVP capture path.
- Decides which camera frames are forwarded downstream by gating the capture block's pixel-valid strobe.
- Supports single-shot and continuous capture, frame decimation, and back-pressure from the frame buffer (drops whole frames only).
- Checks line and pixel counts per frame and reports frame status/statistics. Sits between the DVP capture block and the DCT/frame-buffer input; the pixel data bus bypasses it.

Parameters:
- WIDTH, 1280, expected pixels per line.
- HEIGHT, 720, expected lines per frame.
- SKIP_W, 4, width of skip_n.
- LAG, 2, cycles between a raw href/vsync edge and the last pixel_valid it governs (≥1).

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- vsync  in  1  raw camera vsync, active high.
- href  in  1  raw camera href, active high.
- pix_valid  in  1  pixel strobe from capture block.
- start  in  1  1-cycle arm pulse.
- stop  in  1  1-cycle stop pulse.
- continuous  in  1  1 = re-arm after each frame.
- skip_n  in  SKIP_W  frames discarded before each captured frame.
- buf_ready  in  1  downstream can accept a whole frame.
- pix_valid_o  out  1  gated pixel strobe.
- sof  out  1  start-of-frame marker.
- frame_done  out  1  end-of-frame pulse.
- frame_err  out  1  frame ended with a count error.
- err_code  out  2  bit0 line-count error, bit1 pixel-count error.
- busy  out  1  not IDLE.
- frame_cnt  out  16  captured frames, wraps.
- drop_cnt  out  16  frames dropped for !buf_ready, saturates at 0xFFFF.

Behaviour:
- Reset/async: rst_n low forces IDLE. All outputs, counters, stop_req and error flags are cleared. Reset mid-frame abandons the frame with no frame_done.
- Edge detection: vsync and href are registered once. vs_fall, vs_rise and hr_fall are asserted in the cycle the new level is first seen on the input.
- Delayed events: line_end = hr_fall delayed LAG cycles; frame_end = vs_rise delayed LAG cycles (shift registers).
- State IDLE:
  - busy=0.
  - start -> ARMED, skip_cnt <= skip_n.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins, remain IDLE.
- stop handling: stop sets stop_req. In ARMED/SKIP, stop_req forces IDLE next cycle. In CAPTURE, the frame completes, then IDLE. stop_req is cleared on entering IDLE.
- State ARMED, on vs_fall:
  - skip_cnt≠0: skip_cnt--, go SKIP.
  - skip_cnt=0 and buf_ready=1: go CAPTURE; clear line_cnt, pix_cnt, err flags; set sof_pend.
  - skip_cnt=0 and buf_ready=0: drop_cnt++, go SKIP. skip_cnt stays 0, so the next frame is attempted.
- State SKIP: pix_valid_o=0; on frame_end -> ARMED.
- State CAPTURE:
  - pix_valid_o = pix_valid (combinational AND with state, zero latency).
  - sof = pix_valid & sof_pend, combinational; sof_pend clears on that pixel.
  - Each pix_valid increments pix_cnt, saturating at WIDTH+1.
  - On line_end: if pix_cnt≠WIDTH set pix_err; line_cnt++, saturating at HEIGHT+1; pix_cnt cleared. A pix_valid in the same cycle as line_end counts toward the next line.
  - On frame_end (line_end in the same cycle is processed first):
    - frame_done=1 for 1 cycle (registered).
    - err_code <= {pix_err, line_cnt≠HEIGHT}; frame_err = |err_code, asserted with frame_done.
    - err_code holds until the next frame_done.
    - frame_cnt++ (wraps).
    - Next state: continuous & !stop_req -> ARMED with skip_cnt <= skip_n; else IDLE.
- buf_ready is sampled only at the vs_fall decision; deassertion mid-frame does not abort the capture.
- pix_valid_o is 0 in every state except CAPTURE.

Test Plan:
- WIDTH=8, HEIGHT=4, single-shot, skip_n=0: start, then one 4×8 frame -> 32 pix_valid_o, sof on first pixel, one frame_done with frame_err=0, frame_cnt=1, then IDLE.
- Continuous, skip_n=2, 9 frames -> frames 3, 6 and 9 captured, frame_cnt=3, no pix_valid_o during the others.
- buf_ready=0 at the vs_fall of frames 1–2, then 1 (continuous, skip_n=0) -> drop_cnt=2, frame 3 captured.
- One line with 7 pixels -> err_code=2'b10, frame_err=1. Next frame with 3 lines -> err_code=2'b01.
- stop mid-CAPTURE on line 2 -> frame completes with frame_done, then IDLE, no further pix_valid_o. stop in ARMED -> IDLE next cycle.
- rst_n pulsed mid-frame -> all outputs 0 asynchronously, no frame_done. Subsequent start captures the next full frame cleanly.
